// File: rtl/comm_wr_adr.sv
// Write-side sequencer for the five channel frame buffers: synchronises each
// rdy, produces a delayed write strobe and address, and flags full/overflow.
module comm_wr_adr #(
  parameter int WORDS    = 18,
  parameter int ADR_W    = 5,
  parameter int WR_DELAY = 2,
  parameter int WR_LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy1,
  input  logic             rdy2,
  input  logic             rdy3,
  input  logic             rdy4,
  input  logic             rdy5,
  input  logic             clr1,
  input  logic             clr2,
  input  logic             clr3,
  input  logic             clr4,
  input  logic             clr5,
  output logic             WR1,
  output logic             WR2,
  output logic             WR3,
  output logic             WR4,
  output logic             WR5,
  output logic [ADR_W-1:0] WrAdr1,
  output logic [ADR_W-1:0] WrAdr2,
  output logic [ADR_W-1:0] WrAdr3,
  output logic [ADR_W-1:0] WrAdr4,
  output logic [ADR_W-1:0] WrAdr5,
  output logic             full1,
  output logic             full2,
  output logic             full3,
  output logic             full4,
  output logic             full5,
  output logic             ovf1,
  output logic             ovf2,
  output logic             ovf3,
  output logic             ovf4,
  output logic             ovf5
);

  localparam int NCH = 5;
  localparam logic [3:0]       DLY_LAST = 4'(WR_DELAY - 1);
  localparam logic [3:0]       LEN_LAST = 4'(WR_LEN - 1);
  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, DLY, WRP, FULL} state_t;

  logic [NCH-1:0]   rdy_v, clr_v, wr_v, full_v, ovf_v;
  logic [ADR_W-1:0] adr_v [NCH];

  assign rdy_v = {rdy5, rdy4, rdy3, rdy2, rdy1};
  assign clr_v = {clr5, clr4, clr3, clr2, clr1};

  assign {WR5, WR4, WR3, WR2, WR1}           = wr_v;
  assign {full5, full4, full3, full2, full1} = full_v;
  assign {ovf5, ovf4, ovf3, ovf2, ovf1}      = ovf_v;
  assign WrAdr1 = adr_v[0];
  assign WrAdr2 = adr_v[1];
  assign WrAdr3 = adr_v[2];
  assign WrAdr4 = adr_v[3];
  assign WrAdr5 = adr_v[4];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             wr_q, wr_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             edge_w;

    // sync_q[0]=s0, [1]=s1, [2]=history s2
    assign sync_d = {sync_q[1], sync_q[0], rdy_v[g]};
    assign edge_w = sync_q[1] & ~sync_q[2];

    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      wcnt_d  = wcnt_q;
      wr_d    = wr_q;
      full_d  = full_q;
      ovf_d   = ovf_q;
      adr_d   = adr_q;

      if (edge_w && state_q != IDLE) ovf_d = 1'b1;

      // Clear frees the buffer from any state; in FULL the address is already 0.
      if (clr_v[g]) begin
        state_d = IDLE;
        wr_d    = 1'b0;
        full_d  = 1'b0;
        adr_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (edge_w) begin
              state_d = DLY;
              dcnt_d  = '0;
            end
          end
          DLY: begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q == DLY_LAST) begin
              state_d = WRP;
              wr_d    = 1'b1;
              wcnt_d  = '0;
            end
          end
          WRP: begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == LEN_LAST) begin
              wr_d = 1'b0;
              if (adr_q == ADR_LAST) begin
                adr_d   = '0;
                full_d  = 1'b1;
                state_d = FULL;
              end else begin
                adr_d   = adr_q + 1'b1;
                state_d = IDLE;
              end
            end
          end
          FULL: ;
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= IDLE;
        sync_q  <= '0;
        dcnt_q  <= '0;
        wcnt_q  <= '0;
        wr_q    <= 1'b0;
        full_q  <= 1'b0;
        ovf_q   <= 1'b0;
        adr_q   <= '0;
      end else begin
        state_q <= state_d;
        sync_q  <= sync_d;
        dcnt_q  <= dcnt_d;
        wcnt_q  <= wcnt_d;
        wr_q    <= wr_d;
        full_q  <= full_d;
        ovf_q   <= ovf_d;
        adr_q   <= adr_d;
      end
    end

    assign wr_v[g]   = wr_q;
    assign full_v[g] = full_q;
    assign ovf_v[g]  = ovf_q;
    assign adr_v[g]  = adr_q;
  end

endmodule

// File: tb/tb_comm_wr_adr.sv
// Bench for comm_wr_adr: table of frame steps plus hand sequences, with a
// scoreboard of expected write strobes checked by a negedge monitor.
module tb_comm_wr_adr;

  localparam int WORDS    = 18;
  localparam int ADR_W    = 5;
  localparam int WR_DELAY = 2;
  localparam int WR_LEN   = 4;

  localparam int OP_PULSE = 0;
  localparam int OP_CLR   = 1;
  localparam int OP_DBL   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [5:1]       rdy = '0;
  logic [5:1]       clr = '0;
  logic [5:1]       wr;
  logic [5:1]       full;
  logic [5:1]       ovf;
  logic [ADR_W-1:0] adr [1:5];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int ch;
    int rise;
    int adr;
    int len;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int op;
    int ch;
    bit wr_exp;
    int exp_adr;
    bit exp_full;
    bit exp_ovf;
  } step_t;
  step_t tbl[22];

  int cadr[1:5];
  bit wr_prev[1:5];
  int mon_rise[1:5];
  int mon_len[1:5];
  int mon_adr[1:5];

  comm_wr_adr #(.WORDS(WORDS), .ADR_W(ADR_W), .WR_DELAY(WR_DELAY), .WR_LEN(WR_LEN)) dut (
    .clk(clk), .rst(rst),
    .rdy1(rdy[1]), .rdy2(rdy[2]), .rdy3(rdy[3]), .rdy4(rdy[4]), .rdy5(rdy[5]),
    .clr1(clr[1]), .clr2(clr[2]), .clr3(clr[3]), .clr4(clr[4]), .clr5(clr[5]),
    .WR1(wr[1]), .WR2(wr[2]), .WR3(wr[3]), .WR4(wr[4]), .WR5(wr[5]),
    .WrAdr1(adr[1]), .WrAdr2(adr[2]), .WrAdr3(adr[3]), .WrAdr4(adr[4]), .WrAdr5(adr[5]),
    .full1(full[1]), .full2(full[2]), .full3(full[3]), .full4(full[4]), .full5(full[5]),
    .ovf1(ovf[1]), .ovf2(ovf[2]), .ovf3(ovf[3]), .ovf4(ovf[4]), .ovf5(ovf[5])
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int ch, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s ch%0d @cyc %0d: got %0d, required %0d", name, ch, cyc, act, expv);
    end
  endtask

  // Called at a negedge; rdy is sampled at the next edge k, WR rises at k+4.
  task automatic pulse(input logic [5:1] mask, input int wlen, input bit push);
    for (int c = 1; c <= 5; c++) begin
      if (mask[c] && push) begin
        sb.push_back('{c, cyc + 1 + 2 + WR_DELAY, cadr[c], wlen});
        if (wlen == WR_LEN) cadr[c] = (cadr[c] + 1) % WORDS;
      end
    end
    rdy = rdy | mask;
    repeat (4) @(negedge clk);
    rdy = rdy & ~mask;
  endtask

  // Scoreboard monitor: every WR rise must match a queued expectation.
  initial begin
    for (int c = 1; c <= 5; c++) wr_prev[c] = 1'b0;
    forever begin
      @(negedge clk);
      for (int c = 1; c <= 5; c++) begin
        if (wr[c] && !wr_prev[c]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (sb[i].ch == c && idx < 0) idx = i;
          mon_rise[c] = cyc;
          if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_wr ch%0d: WR rose at cycle %0d, required no write", c, cyc);
            mon_len[c] = -1;
            mon_adr[c] = int'(adr[c]);
          end else begin
            chk("wr_rise_cycle", c, cyc, sb[idx].rise);
            chk("wr_adr", c, int'(adr[c]), sb[idx].adr);
            mon_len[c] = sb[idx].len;
            mon_adr[c] = sb[idx].adr;
            sb.delete(idx);
          end
        end else if (wr[c] && wr_prev[c]) begin
          chk("wr_adr_stable", c, int'(adr[c]), mon_adr[c]);
        end else if (!wr[c] && wr_prev[c]) begin
          chk("wr_len", c, cyc - mon_rise[c], mon_len[c]);
        end
        wr_prev[c] = wr[c];
      end
    end
  end

  initial begin
    for (int c = 1; c <= 5; c++) cadr[c] = 0;
    for (int i = 0; i < 18; i++)
      tbl[i] = '{OP_PULSE, 2, 1'b1, (i + 1) % WORDS, (i == 17), 1'b0};
    tbl[18] = '{OP_PULSE, 2, 1'b0, 0, 1'b1, 1'b1};
    tbl[19] = '{OP_CLR,   2, 1'b0, 0, 1'b0, 1'b1};
    tbl[20] = '{OP_PULSE, 2, 1'b1, 1, 1'b0, 1'b1};
    tbl[21] = '{OP_DBL,   3, 1'b1, 1, 1'b0, 1'b1};

    // Reset state
    repeat (4) @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      chk("rst_wr", c, int'(wr[c]), 0);
      chk("rst_full", c, int'(full[c]), 0);
      chk("rst_ovf", c, int'(ovf[c]), 0);
      chk("rst_adr", c, int'(adr[c]), 0);
    end
    rst = 1'b1;

    // Channel 1: rdy sampled at edges 10..13, WR high after edges 14..17
    while (cyc < 9) @(negedge clk);
    rdy[1] = 1'b1;
    sb.push_back('{1, 14, 0, WR_LEN});
    cadr[1] = 1;
    while (cyc < 18) begin
      @(negedge clk);
      if (cyc == 13) begin
        rdy[1] = 1'b0;
        chk("c1_wr_before", 1, int'(wr[1]), 0);
      end
      if (cyc == 14) begin
        chk("c1_wr_rise", 1, int'(wr[1]), 1);
        chk("c1_adr_rise", 1, int'(adr[1]), 0);
      end
      if (cyc == 17) chk("c1_wr_last", 1, int'(wr[1]), 1);
      if (cyc == 18) begin
        chk("c1_wr_fall", 1, int'(wr[1]), 0);
        chk("c1_adr_after", 1, int'(adr[1]), 1);
        chk("c1_full", 1, int'(full[1]), 0);
      end
    end
    repeat (4) @(negedge clk);

    // Table: channel 2 frame, overflow, clear, restart; channel 3 double edge
    for (int i = 0; i < 22; i++) begin
      int ch;
      ch = tbl[i].ch;
      case (tbl[i].op)
        OP_PULSE: begin
          pulse(5'(1 << (ch - 1)), WR_LEN, tbl[i].wr_exp);
          repeat (16) @(negedge clk);
        end
        OP_CLR: begin
          clr[ch] = 1'b1;
          @(negedge clk);
          clr[ch] = 1'b0;
          chk("clr_full_next", ch, int'(full[ch]), 0);
          cadr[ch] = 0;
          repeat (19) @(negedge clk);
        end
        default: begin
          sb.push_back('{ch, cyc + 1 + 2 + WR_DELAY, cadr[ch], WR_LEN});
          cadr[ch] = (cadr[ch] + 1) % WORDS;
          rdy[ch] = 1'b1;
          repeat (2) @(negedge clk);
          rdy[ch] = 1'b0;
          @(negedge clk);
          rdy[ch] = 1'b1;
          repeat (2) @(negedge clk);
          rdy[ch] = 1'b0;
          repeat (15) @(negedge clk);
        end
      endcase
      chk("step_adr", ch, int'(adr[ch]), tbl[i].exp_adr);
      chk("step_full", ch, int'(full[ch]), int'(tbl[i].exp_full));
      chk("step_ovf", ch, int'(ovf[ch]), int'(tbl[i].exp_ovf));
    end

    // Channel 4: advance to address 5, then clear in the middle of the write
    for (int i = 0; i < 5; i++) begin
      pulse(5'b01000, WR_LEN, 1'b1);
      repeat (16) @(negedge clk);
    end
    pulse(5'b01000, 2, 1'b1);
    repeat (2) @(negedge clk);
    chk("c4_wr_mid", 4, int'(wr[4]), 1);
    chk("c4_adr_mid", 4, int'(adr[4]), 5);
    clr[4] = 1'b1;
    @(negedge clk);
    clr[4] = 1'b0;
    chk("c4_wr_abort", 4, int'(wr[4]), 0);
    chk("c4_adr_abort", 4, int'(adr[4]), 0);
    cadr[4] = 0;
    repeat (16) @(negedge clk);
    pulse(5'b01000, WR_LEN, 1'b1);
    repeat (16) @(negedge clk);
    chk("c4_adr_restart", 4, int'(adr[4]), 1);
    chk("c4_ovf", 4, int'(ovf[4]), 0);

    // All channels together; scoreboard checks identical timing per channel
    pulse(5'b11111, WR_LEN, 1'b1);
    repeat (16) @(negedge clk);
    for (int c = 1; c <= 5; c++) chk("all_adr", c, int'(adr[c]), cadr[c]);

    // Reset while every WR is high
    pulse(5'b11111, 1, 1'b1);
    @(negedge clk);
    for (int c = 1; c <= 5; c++) chk("pre_rst_wr", c, int'(wr[c]), 1);
    rst = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      chk("midrst_wr", c, int'(wr[c]), 0);
      chk("midrst_adr", c, int'(adr[c]), 0);
      chk("midrst_full", c, int'(full[c]), 0);
      chk("midrst_ovf", c, int'(ovf[c]), 0);
      cadr[c] = 0;
    end
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("sb_empty", 0, sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
